// File: rtl/alarm_set_ctrl_if.sv
// ============================================================================
// Module      : alarm_set_ctrl_if
// Description : Keypad-side inputs and alarm-register-side outputs of the
//               alarm entry controller, bundled with master/slave views.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alarm_set_ctrl_if;
    logic       one_second;
    logic       alarm_button;
    logic       cancel;
    logic [3:0] key;
    logic       key_valid;
    logic [3:0] new_alarm_ms_hr;
    logic [3:0] new_alarm_ls_hr;
    logic [3:0] new_alarm_ms_min;
    logic [3:0] new_alarm_ls_min;
    logic       load_new_alarm;
    logic       entry_active;
    logic [1:0] digit_pos;
    logic       key_error;
    logic       timeout;

    modport master (
        output one_second, alarm_button, cancel, key, key_valid,
        input  new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min,
        input  load_new_alarm, entry_active, digit_pos, key_error, timeout
    );

    modport slave (
        input  one_second, alarm_button, cancel, key, key_valid,
        output new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min,
        output load_new_alarm, entry_active, digit_pos, key_error, timeout
    );
endinterface

`default_nettype wire

// File: rtl/alarm_set_ctrl.sv
// ============================================================================
// Module      : alarm_set_ctrl
// Description : Collects and validates four BCD alarm digits (HH:MM, 24 h),
//               then strobes them into the alarm register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alarm_set_ctrl #(
    parameter int TIMEOUT_SEC = 10
) (
    input  wire logic        clock,
    input  wire logic        reset,
    alarm_set_ctrl_if.slave  bus
);
    localparam logic [3:0] C_TIMEOUT = 4'(TIMEOUT_SEC);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_D0     = 3'd1,
        S_D1     = 3'd2,
        S_D2     = 3'd3,
        S_D3     = 3'd4,
        S_COMMIT = 3'd5
    } state_t;

    state_t          r_state, w_state_nxt, w_state_adv;
    logic [3:0][3:0] r_buf, w_buf_nxt;
    logic [3:0]      r_cnt, w_cnt_nxt, w_cnt_inc, w_limit;
    logic [1:0]      w_idx, w_pos_nxt;
    logic            w_key_err, w_timeout;
    logic            r_load, r_active, r_key_err, r_timeout;
    logic [1:0]      r_pos;

    assign w_cnt_inc = r_cnt + 4'd1;

    // Per-state digit slot, upper limit of the accepted key and successor state
    always_comb begin
        w_idx       = 2'd0;
        w_limit     = 4'd9;
        w_state_adv = S_IDLE;
        case (r_state)
            S_D0: begin w_idx = 2'd0; w_limit = 4'd2; w_state_adv = S_D1; end
            S_D1: begin
                w_idx       = 2'd1;
                w_limit     = (r_buf[0] == 4'd2) ? 4'd3 : 4'd9;
                w_state_adv = S_D2;
            end
            S_D2: begin w_idx = 2'd2; w_limit = 4'd5; w_state_adv = S_D3; end
            S_D3: begin w_idx = 2'd3; w_limit = 4'd9; w_state_adv = S_COMMIT; end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_buf_nxt   = r_buf;
        w_cnt_nxt   = r_cnt;
        w_key_err   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.alarm_button) begin
                    w_state_nxt = S_D0;
                    w_buf_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            end
            S_COMMIT: w_state_nxt = S_IDLE;
            default: begin
                if (bus.cancel) begin
                    w_state_nxt = S_IDLE;
                end else if (bus.alarm_button) begin
                    w_state_nxt = S_D0;
                    w_buf_nxt   = '0;
                    w_cnt_nxt   = '0;
                end else if (bus.key_valid) begin
                    w_cnt_nxt = '0;
                    // Limits never exceed 9, so non-BCD codes always fall out here
                    if (bus.key <= w_limit) begin
                        w_buf_nxt[w_idx] = bus.key;
                        w_state_nxt      = w_state_adv;
                    end else begin
                        w_key_err = 1'b1;
                    end
                end else if (bus.one_second) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == C_TIMEOUT) begin
                        w_state_nxt = S_IDLE;
                        w_timeout   = 1'b1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        w_pos_nxt = 2'd0;
        case (w_state_nxt)
            S_D1:    w_pos_nxt = 2'd1;
            S_D2:    w_pos_nxt = 2'd2;
            S_D3:    w_pos_nxt = 2'd3;
            default: w_pos_nxt = 2'd0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_buf     <= '0;
            r_cnt     <= '0;
            r_load    <= 1'b0;
            r_active  <= 1'b0;
            r_pos     <= 2'd0;
            r_key_err <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_buf     <= w_buf_nxt;
            r_cnt     <= w_cnt_nxt;
            r_load    <= (w_state_nxt == S_COMMIT);
            r_active  <= (w_state_nxt != S_IDLE);
            r_pos     <= w_pos_nxt;
            r_key_err <= w_key_err;
            r_timeout <= w_timeout;
        end
    end

    assign bus.new_alarm_ms_hr  = r_buf[0];
    assign bus.new_alarm_ls_hr  = r_buf[1];
    assign bus.new_alarm_ms_min = r_buf[2];
    assign bus.new_alarm_ls_min = r_buf[3];
    assign bus.load_new_alarm   = r_load;
    assign bus.entry_active     = r_active;
    assign bus.digit_pos        = r_pos;
    assign bus.key_error        = r_key_err;
    assign bus.timeout          = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_alarm_set_ctrl.sv
// ============================================================================
// Module      : tb_alarm_set_ctrl
// Description : Directed and random stimulus for alarm_set_ctrl, checked each
//               cycle against a behavioural model of the entry rules.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alarm_set_ctrl;
    localparam int TO = 10;

    logic clock = 1'b0;
    logic reset = 1'b0;
    alarm_set_ctrl_if bus();

    alarm_set_ctrl #(.TIMEOUT_SEC(TO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: position -1 = idle, 0..3 = awaiting that digit, 4 = committing
    int m_pos = -1;
    int m_dig [4] = '{0, 0, 0, 0};
    int m_cnt = 0;
    bit m_err = 1'b0;
    bit m_to  = 1'b0;

    function automatic int max_key(input int p, input int hr_tens);
        if (p == 0) return 2;
        if (p == 1) return (hr_tens == 2) ? 3 : 9;
        if (p == 2) return 5;
        return 9;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_pos = -1; m_dig = '{0, 0, 0, 0}; m_cnt = 0; m_err = 0; m_to = 0;
        end else begin
            m_err = 0; m_to = 0;
            if (m_pos == 4) begin
                m_pos = -1;
            end else if (m_pos == -1) begin
                if (bus.alarm_button) begin m_pos = 0; m_dig = '{0, 0, 0, 0}; m_cnt = 0; end
            end else if (bus.cancel) begin
                m_pos = -1;
            end else if (bus.alarm_button) begin
                m_pos = 0; m_dig = '{0, 0, 0, 0}; m_cnt = 0;
            end else if (bus.key_valid) begin
                m_cnt = 0;
                if (int'(bus.key) <= max_key(m_pos, m_dig[0])) begin
                    m_dig[m_pos] = int'(bus.key);
                    m_pos++;
                end else begin
                    m_err = 1;
                end
            end else if (bus.one_second) begin
                m_cnt++;
                if (m_cnt == TO) begin m_pos = -1; m_to = 1; end
            end
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clock) begin
        if (cmp_en) begin
            check("buffer", {bus.new_alarm_ms_hr, bus.new_alarm_ls_hr, bus.new_alarm_ms_min, bus.new_alarm_ls_min},
                  {m_dig[0][3:0], m_dig[1][3:0], m_dig[2][3:0], m_dig[3][3:0]});
            check("load_new_alarm", 16'(bus.load_new_alarm), 16'(m_pos == 4));
            check("entry_active",   16'(bus.entry_active),   16'(m_pos != -1));
            check("digit_pos",      16'(bus.digit_pos),      (m_pos >= 0 && m_pos <= 3) ? 16'(m_pos) : 16'd0);
            check("key_error",      16'(bus.key_error),      16'(m_err));
            check("timeout",        16'(bus.timeout),        16'(m_to));
        end
    end

    task automatic drv(input bit b, input bit c, input bit kv, input logic [3:0] k, input bit s);
        @(negedge clock);
        bus.alarm_button = b; bus.cancel = c; bus.key_valid = kv; bus.key = k; bus.one_second = s;
    endtask

    task automatic key(input logic [3:0] k); drv(0, 0, 1, k, 0); endtask
    task automatic idle();                   drv(0, 0, 0, 4'd0, 0); endtask
    task automatic settle();                 @(posedge clock); #1; endtask

    function automatic logic [15:0] buf_val();
        return {bus.new_alarm_ms_hr, bus.new_alarm_ls_hr, bus.new_alarm_ms_min, bus.new_alarm_ls_min};
    endfunction

    initial begin
        bus.alarm_button = 0; bus.cancel = 0; bus.key_valid = 0; bus.key = 0; bus.one_second = 0;
        repeat (2) @(negedge clock);
        check("rst buffer", buf_val(), 16'h0000);
        check("rst active", 16'(bus.entry_active), 16'd0);
        check("rst load",   16'(bus.load_new_alarm), 16'd0);
        reset = 1'b1;
        cmp_en = 1'b1;

        // Straight entry 1,2,3,4 on consecutive cycles
        drv(1, 0, 0, 0, 0);
        key(1); key(2); key(3); key(4); settle();
        check("t1 load", 16'(bus.load_new_alarm), 16'd1);
        check("t1 buf",  buf_val(), 16'h1234);
        idle(); settle();
        check("t1 load drop",   16'(bus.load_new_alarm), 16'd0);
        check("t1 active drop", 16'(bus.entry_active), 16'd0);

        // Hour limits: 3 rejected, then 2, 4 rejected, then 2 5 9
        drv(1, 0, 0, 0, 0);
        key(3); settle();
        check("t2 err3", 16'(bus.key_error), 16'd1);
        key(2); key(4); settle();
        check("t2 err4", 16'(bus.key_error), 16'd1);
        check("t2 pos",  16'(bus.digit_pos), 16'd1);
        key(2); key(5); key(9); settle();
        check("t2 load", 16'(bus.load_new_alarm), 16'd1);
        check("t2 buf",  buf_val(), 16'h2259);
        idle();

        // Minute-tens limit
        drv(1, 0, 0, 0, 0);
        key(0); key(9); key(7); settle();
        check("t3 err", 16'(bus.key_error), 16'd1);
        check("t3 pos", 16'(bus.digit_pos), 16'd2);
        key(5); key(0); settle();
        check("t3 buf", buf_val(), 16'h0950);
        idle();

        // Inactivity timeout on the 10th tick
        drv(1, 0, 0, 0, 0);
        key(1); key(2);
        repeat (TO - 1) drv(0, 0, 0, 0, 1);
        drv(0, 0, 0, 0, 1); settle();
        check("t4 timeout", 16'(bus.timeout), 16'd1);
        check("t4 active",  16'(bus.entry_active), 16'd0);
        check("t4 load",    16'(bus.load_new_alarm), 16'd0);
        idle(); settle();
        check("t4 pulse", 16'(bus.timeout), 16'd0);

        // Key coinciding with the 10th tick keeps entry alive
        drv(1, 0, 0, 0, 0);
        key(1); key(2);
        repeat (TO - 1) drv(0, 0, 0, 0, 1);
        drv(0, 0, 1, 4'd3, 1); settle();
        check("t4b timeout", 16'(bus.timeout), 16'd0);
        check("t4b pos",     16'(bus.digit_pos), 16'd3);
        drv(0, 1, 0, 0, 0);

        // Cancel beats a simultaneous key; button restarts from D2
        drv(1, 0, 0, 0, 0);
        key(1); key(2);
        drv(0, 1, 1, 4'd3, 0); settle();
        check("t5 active", 16'(bus.entry_active), 16'd0);
        check("t5 err",    16'(bus.key_error), 16'd0);
        drv(1, 0, 0, 0, 0);
        key(1); key(2);
        drv(1, 0, 1, 4'd3, 0); settle();
        check("t5 pos", 16'(bus.digit_pos), 16'd0);
        check("t5 buf", buf_val(), 16'h0000);
        drv(0, 1, 0, 0, 0);

        // Asynchronous reset while in D3
        drv(1, 0, 0, 0, 0);
        key(1); key(2); key(3);
        idle();
        #1 reset = 1'b0;
        #1;
        check("t6 active", 16'(bus.entry_active), 16'd0);
        check("t6 buf",    buf_val(), 16'h0000);
        check("t6 pos",    16'(bus.digit_pos), 16'd0);
        @(negedge clock); reset = 1'b1;
        key(4); settle();
        check("t6 load", 16'(bus.load_new_alarm), 16'd0);
        idle(); settle();
        check("t6 load2", 16'(bus.load_new_alarm), 16'd0);

        // Random traffic: keypad-heavy then tick-heavy
        for (int i = 0; i < 4000; i++) begin
            bit b, c, kv, s;
            if (i < 2000) begin
                b  = ($urandom_range(0, 19) == 0);
                c  = ($urandom_range(0, 39) == 0);
                kv = ($urandom_range(0, 9) < 5);
                s  = ($urandom_range(0, 4) == 0);
            end else begin
                b  = ($urandom_range(0, 29) == 0);
                c  = ($urandom_range(0, 99) == 0);
                kv = ($urandom_range(0, 19) == 0);
                s  = ($urandom_range(0, 1) == 0);
            end
            drv(b, c, kv, 4'($urandom_range(0, 11)), s);
        end
        idle(); idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/alarm_set_ctrl.md
# alarm_set_ctrl

Keypad-entry controller that sequences loading of the alarm-time register. It collects four BCD digits from the keypad in the order hours-tens, hours-units, minutes-tens, minutes-units, and validates each against 24-hour limits. It then presents the digits on the alarm register's `new_alarm_*` inputs with a one-cycle `load_new_alarm` strobe. It sits between the keypad decoder and the alarm register and aborts entry on cancel or inactivity timeout.

## Interface
- `TIMEOUT_SEC`, default 10: seconds of keypad inactivity before entry aborts; legal range 1-15.
- `clock` input 1: single system clock, rising edge.
- `reset` input 1: asynchronous, active-low.
- `one_second` input 1: one-cycle tick, once per second.
- `alarm_button` input 1: one-cycle strobe that starts or restarts entry.
- `cancel` input 1: one-cycle strobe that aborts entry.
- `key` input 4: BCD digit; sampled only when `key_valid`=1.
- `key_valid` input 1: one-cycle strobe; `key` is valid.
- `new_alarm_ms_hr`, `new_alarm_ls_hr`, `new_alarm_ms_min`, `new_alarm_ls_min` output 4 each: digit buffer driven to the alarm register.
- `load_new_alarm` output 1: one-cycle commit strobe.
- `entry_active` output 1: high in any state except IDLE.
- `digit_pos` output 2: index of the next expected digit (0=ms_hr … 3=ls_min); 0 in IDLE.
- `key_error` output 1: one-cycle pulse when a key is rejected.
- `timeout` output 1: one-cycle pulse when entry aborts on inactivity.

## Operation
- States: IDLE, D0 (ms_hr), D1 (ls_hr), D2 (ms_min), D3 (ls_min), COMMIT.
- IDLE: `alarm_button` moves to D0, clears the digit buffer to 0 and clears the inactivity counter. `key_valid` is ignored and raises no error.
- Digit acceptance rules:
  - D0 accepts 0-2.
  - D1 accepts 0-9 if ms_hr<2, and 0-3 if ms_hr=2.
  - D2 accepts 0-5.
  - D3 accepts 0-9.
  - Any key value ≥10 is rejected.
- Accepted key: written into that state's buffer digit; the FSM advances one state.
- Rejected key: the state and buffer are unchanged and `key_error` pulses.
- D3 with an accepted key goes to COMMIT. COMMIT asserts `load_new_alarm` for exactly one cycle, then returns to IDLE unconditionally.
- The buffer holds its value after commit and abort; the alarm register ignores it unless `load_new_alarm`=1.
- Inactivity counter:
  - 4 bits; clears on entry to D0 and on every `key_valid` in D0-D3, whether the key is accepted or rejected.
  - Otherwise increments on `one_second` while in D0-D3.
  - When the count reaches `TIMEOUT_SEC`, the FSM goes to IDLE and `timeout` pulses; no load occurs.
- Priority for events in the same cycle:
  1. `cancel`: in D0-D3, go to IDLE with no load and no error.
  2. `alarm_button`: in D0-D3, restart at D0 and clear the buffer; the key is ignored.
  3. `key_valid`.
  4. Timeout. A key in the timeout cycle clears the counter, so the key wins.
- COMMIT ignores all inputs for its one cycle, and the load always completes.

## Timing
- All outputs are registered.
- Reset values: buffer digits 0, `load_new_alarm`=0, `entry_active`=0, `digit_pos`=0, `key_error`=0, `timeout`=0, FSM=IDLE, counter=0.
- Assertion of `reset` takes effect immediately, mid-entry included; no load is issued.
- `key_valid` sampled at edge N:
  - buffer and `digit_pos` update at edge N;
  - `key_error` is high during cycle N+1.
- `load_new_alarm` is high for the single cycle after the 4th accepted key's edge. The buffer is already stable with the final digits in that cycle.
- Back-to-back `key_valid` on consecutive cycles is supported: one digit per cycle.
- Latency from `alarm_button` to first digit acceptance: key may arrive the cycle after.
- `timeout` is high during the cycle following the `one_second` edge that reaches the limit. `entry_active` falls at the same edge.

## Test plan
- Reset, `alarm_button`, keys 1,2,3,4 on consecutive cycles -> buffer 1/2/3/4, `load_new_alarm` one cycle after key 4, `entry_active` drops the next cycle.
- Entry with keys 3, 2, 4, 2, 5, 9 -> 3 rejected (`key_error`), then 2 accepted, 4 rejected (hour >23), then 2, 5, 9 accepted; commit 2/2/5/9.
- Keys 0, 9, 7 (minutes-tens) -> 7 rejected, `digit_pos` stays 2; then 5, 0 -> commit 0/9/5/0.
- Keys 1, 2, then 10 `one_second` ticks with `TIMEOUT_SEC`=10 -> `timeout` pulses on the 10th tick, no load, IDLE; a key on the 10th-tick cycle instead keeps entry alive.
- Keys 1, 2 with `cancel` and `key_valid` asserted together -> IDLE, no load, no error. `alarm_button` during D2 -> back to D0, buffer 0.
- `reset` pulsed low in D3 -> all outputs at reset values immediately; no `load_new_alarm` afterwards.
